// File: rtl/decay_timer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | decay_timer_pkg                                                            |
// | Shared state encoding and FIFO sizing helpers for the muon decay timer.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package decay_timer_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    TIMING = 1'b1
  } state_e;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int FIFO_DEPTH_DEF = 4;
  localparam int FIFO_PTR_W     = ptr_width(FIFO_DEPTH_DEF);

endpackage
`default_nettype wire

// File: rtl/decay_timer_interval_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | interval_fifo                                                              |
// | First-word-fall-through synchronous FIFO; output holds while empty.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module interval_fifo
  import decay_timer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] last_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? last_q : mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CNT_W'(1);
      end
      if (!empty) begin
        last_q <= mem_q[rd_ptr_q];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/decay_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | decay_timer                                                                |
// | Measures start-to-stop coincidence intervals, queues them, keeps stats.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module decay_timer
  import decay_timer_pkg::*;
#(
  parameter int TIME_WIDTH = 16,
  parameter int MAX_WINDOW = 2000,
  parameter int MIN_DELTA  = 2,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  coincidence_in,
  output logic                  event_valid,
  input  logic                  event_ready,
  output logic [TIME_WIDTH-1:0] event_time,
  output logic                  busy,
  output logic [STAT_WIDTH-1:0] timeout_count,
  output logic [STAT_WIDTH-1:0] drop_count
);

  localparam logic [TIME_WIDTH-1:0] MAX_K = TIME_WIDTH'(MAX_WINDOW);
  localparam logic [TIME_WIDTH-1:0] MIN_K = TIME_WIDTH'(MIN_DELTA);

  state_e                  state_q;
  state_e                  state_d;
  logic [TIME_WIDTH-1:0]   cnt_q;
  logic [TIME_WIDTH-1:0]   cnt_d;
  logic                    busy_q;
  logic [STAT_WIDTH-1:0]   timeout_q;
  logic [STAT_WIDTH-1:0]   drop_q;

  logic                    stop_hit;
  logic                    timeout_hit;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    fifo_pop;
  logic                    drop_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == TIMING);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (coincidence_in) begin
          state_d = TIMING;
          cnt_d   = TIME_WIDTH'(1);
        end
      end
      TIMING: begin
        if (coincidence_in && (cnt_q >= MIN_K)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == MAX_K) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + TIME_WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A stop at exactly MAX_WINDOW wins over the timeout.
  always_comb begin
    stop_hit    = 1'b0;
    timeout_hit = 1'b0;
    if (state_q == TIMING) begin
      stop_hit    = coincidence_in && (cnt_q >= MIN_K);
      timeout_hit = !stop_hit && (cnt_q == MAX_K);
    end
  end

  assign fifo_pop = event_valid && event_ready;
  assign drop_hit = stop_hit && fifo_full && !fifo_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_q <= '0;
      drop_q    <= '0;
    end else begin
      if (timeout_hit && (timeout_q != '1)) begin
        timeout_q <= timeout_q + STAT_WIDTH'(1);
      end
      if (drop_hit && (drop_q != '1)) begin
        drop_q <= drop_q + STAT_WIDTH'(1);
      end
    end
  end

  interval_fifo #(
    .WIDTH (TIME_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (stop_hit),
    .din   (cnt_q),
    .pop   (fifo_pop),
    .dout  (event_time),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign event_valid   = !fifo_empty;
  assign busy          = busy_q;
  assign timeout_count = timeout_q;
  assign drop_count    = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_decay_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_decay_timer                                                             |
// | Directed self-checking bench for decay_timer.                              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_decay_timer;

  logic        clk;
  logic        rst;
  logic        coincidence_in;
  logic        event_valid;
  logic        event_ready;
  logic [15:0] event_time;
  logic        busy;
  logic [15:0] timeout_count;
  logic [15:0] drop_count;

  int tests;
  int fails;

  decay_timer #(
    .TIME_WIDTH (16),
    .MAX_WINDOW (2000),
    .MIN_DELTA  (2),
    .FIFO_DEPTH (4),
    .STAT_WIDTH (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .coincidence_in (coincidence_in),
    .event_valid    (event_valid),
    .event_ready    (event_ready),
    .event_time     (event_time),
    .busy           (busy),
    .timeout_count  (timeout_count),
    .drop_count     (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  // One-cycle pulse launched at a falling edge; returns at the next falling edge.
  task automatic send_pulse();
    coincidence_in = 1'b1;
    @(negedge clk);
    coincidence_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; coincidence_in = 1'b0; event_ready = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b want 0", busy); end
    tests++; if (event_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b want 0", event_valid); end
    tests++; if (event_time !== 16'd0) begin fails++; $display("FAIL reset_time: got %0d want 0", event_time); end
    tests++; if (timeout_count !== 16'd0) begin fails++; $display("FAIL reset_timeout: got %0d want 0", timeout_count); end
    tests++; if (drop_count !== 16'd0) begin fails++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    send_pulse();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy_start: got %0b want 1", busy); end
    repeat (298) @(negedge clk);
    tests++; if (busy !== 1'b1 || event_valid !== 1'b0) begin fails++; $display("FAIL basic_k299: busy %0b valid %0b want 1 0", busy, event_valid); end
    @(negedge clk);
    send_pulse();
    tests++; if (event_valid !== 1'b1) begin fails++; $display("FAIL basic_valid: got %0b want 1", event_valid); end
    tests++; if (event_time !== 16'd300) begin fails++; $display("FAIL basic_time: got %0d want 300", event_time); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_end: got %0b want 0", busy); end
    event_ready = 1'b1;
    @(negedge clk);
    event_ready = 1'b0;
    tests++; if (event_valid !== 1'b0) begin fails++; $display("FAIL basic_pop: valid got %0b want 0", event_valid); end
    tests++; if (event_time !== 16'd300) begin fails++; $display("FAIL basic_hold: got %0d want 300", event_time); end
  endtask

  task automatic test_too_early();
    send_pulse();
    send_pulse();
    tests++; if (busy !== 1'b1 || event_valid !== 1'b0) begin fails++; $display("FAIL early_ignored: busy %0b valid %0b want 1 0", busy, event_valid); end
    repeat (48) @(negedge clk);
    send_pulse();
    tests++; if (event_valid !== 1'b1 || event_time !== 16'd50) begin fails++; $display("FAIL early_time: valid %0b time %0d want 1 50", event_valid, event_time); end
    event_ready = 1'b1;
    @(negedge clk);
    event_ready = 1'b0;
    tests++; if (event_valid !== 1'b0) begin fails++; $display("FAIL early_single: valid got %0b want 0", event_valid); end
    send_pulse();
    @(negedge clk);
    send_pulse();
    tests++; if (event_valid !== 1'b1 || event_time !== 16'd2 || busy !== 1'b0) begin fails++; $display("FAIL min_delta: valid %0b time %0d busy %0b want 1 2 0", event_valid, event_time, busy); end
    event_ready = 1'b1;
    @(negedge clk);
    event_ready = 1'b0;
  endtask

  task automatic test_window();
    send_pulse();
    repeat (1999) @(negedge clk);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL window_busy: got %0b want 1", busy); end
    send_pulse();
    tests++; if (event_valid !== 1'b1 || event_time !== 16'd2000) begin fails++; $display("FAIL window_edge: valid %0b time %0d want 1 2000", event_valid, event_time); end
    tests++; if (timeout_count !== 16'd0) begin fails++; $display("FAIL window_no_timeout: got %0d want 0", timeout_count); end
    event_ready = 1'b1;
    @(negedge clk);
    event_ready = 1'b0;
    send_pulse();
    repeat (1999) @(negedge clk);
    tests++; if (busy !== 1'b1 || timeout_count !== 16'd0) begin fails++; $display("FAIL timeout_k2000: busy %0b count %0d want 1 0", busy, timeout_count); end
    @(negedge clk);
    tests++; if (timeout_count !== 16'd1 || busy !== 1'b0 || event_valid !== 1'b0) begin fails++; $display("FAIL timeout: count %0d busy %0b valid %0b want 1 0 0", timeout_count, busy, event_valid); end
    send_pulse();
    repeat (9) @(negedge clk);
    send_pulse();
    tests++; if (event_valid !== 1'b1 || event_time !== 16'd10 || timeout_count !== 16'd1) begin fails++; $display("FAIL restart: valid %0b time %0d tmo %0d want 1 10 1", event_valid, event_time, timeout_count); end
    event_ready = 1'b1;
    @(negedge clk);
    event_ready = 1'b0;
  endtask

  task automatic test_fifo_full();
    logic [15:0] exp_q [4];
    exp_q[0] = 16'd101; exp_q[1] = 16'd102; exp_q[2] = 16'd103; exp_q[3] = 16'd55;
    for (int i = 0; i < 5; i++) begin
      send_pulse();
      repeat (99 + i) @(negedge clk);
      send_pulse();
    end
    tests++; if (drop_count !== 16'd1) begin fails++; $display("FAIL full_drop: got %0d want 1", drop_count); end
    tests++; if (event_valid !== 1'b1 || event_time !== 16'd100) begin fails++; $display("FAIL full_head: valid %0b time %0d want 1 100", event_valid, event_time); end
    send_pulse();
    repeat (54) @(negedge clk);
    event_ready = 1'b1;
    send_pulse();
    event_ready = 1'b0;
    tests++; if (drop_count !== 16'd1) begin fails++; $display("FAIL pushpop_drop: got %0d want 1", drop_count); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (event_valid !== 1'b1 || event_time !== exp_q[i]) begin fails++; $display("FAIL drain_%0d: valid %0b time %0d want 1 %0d", i, event_valid, event_time, exp_q[i]); end
      event_ready = 1'b1;
      @(negedge clk);
    end
    event_ready = 1'b0;
    tests++; if (event_valid !== 1'b0) begin fails++; $display("FAIL drain_empty: valid got %0b want 0", event_valid); end
  endtask

  task automatic test_async_reset();
    send_pulse();
    repeat (6) @(negedge clk);
    send_pulse();
    send_pulse();
    repeat (499) @(negedge clk);
    tests++; if (busy !== 1'b1 || event_valid !== 1'b1 || timeout_count !== 16'd1) begin fails++; $display("FAIL prereset: busy %0b valid %0b tmo %0d want 1 1 1", busy, event_valid, timeout_count); end
    #2 rst = 1'b1;
    #1;
    tests++; if (busy !== 1'b0 || event_valid !== 1'b0) begin fails++; $display("FAIL areset_busy_valid: busy %0b valid %0b want 0 0", busy, event_valid); end
    tests++; if (timeout_count !== 16'd0 || drop_count !== 16'd0) begin fails++; $display("FAIL areset_stats: tmo %0d drop %0d want 0 0", timeout_count, drop_count); end
    tests++; if (event_time !== 16'd0) begin fails++; $display("FAIL areset_time: got %0d want 0", event_time); end
    @(negedge clk);
    rst = 1'b0;
    repeat (600) @(negedge clk);
    tests++; if (event_valid !== 1'b0 || busy !== 1'b0 || timeout_count !== 16'd0) begin fails++; $display("FAIL post_reset: valid %0b busy %0b tmo %0d want 0 0 0", event_valid, busy, timeout_count); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    coincidence_in = 1'b0;
    event_ready = 1'b0;
    test_reset();
    test_basic();
    test_too_early();
    test_window();
    test_fifo_full();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
